// File: rtl/cut_dat_pad.sv
// Frame restorer: re-pads cut data segments back to full frame length with fill words.
// Optional macro CUT_PAD_TAG_EN puts a frame sequence tag on the first fill word of each frame.
module cut_dat_pad #(
    parameter int unsigned BUF_AW   = 4,
    parameter logic [12:0] AFULL_TH = 13'd4000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_en,
    input  logic        stop_en,
    input  logic [31:0] total_num,
    input  logic [31:0] cut_num,
    input  logic        en_in,
    input  logic [15:0] dat_in,
    input  logic [15:0] fill_dat,
    input  logic [12:0] fifo_wrnum,
    output logic        wr_en,
    output logic [15:0] wr_dat,
    output logic        busy,
    output logic        ovf
);

    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 32;
    localparam int unsigned PW    = BUF_AW + 1;
    localparam int unsigned DEPTH = 1 << BUF_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            start_r0_q, start_r0_d, start_r1_q, start_r1_d;
    logic            stop_r0_q, stop_r0_d, stop_r1_q, stop_r1_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   tot_q, tot_d;
    logic [CW-1:0]   ceff_q, ceff_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [DW-1:0]   wr_dat_q, wr_dat_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
`ifdef CUT_PAD_TAG_EN
    logic [15:0]     frame_seq_q, frame_seq_d;
`endif

    logic [DW-1:0]   buf_mem [DEPTH];
    logic [DW-1:0]   rd_word;
    logic            start_edge;
    logic            stop_edge;
    logic            space;
    logic            buf_empty;
    logic            buf_full;
    logic [CW-1:0]   ceff_new;
    logic            flush;
    logic            pop;
    logic            push_req;
    logic            push_ok;

    assign start_edge = start_r0_q && !start_r1_q;
    assign stop_edge  = stop_r0_q && !stop_r1_q;
    assign space      = (fifo_wrnum <= AFULL_TH);
    assign buf_empty  = (wr_ptr_q == rd_ptr_q);
    assign buf_full   = (wr_ptr_q[BUF_AW] != rd_ptr_q[BUF_AW]) &&
                        (wr_ptr_q[BUF_AW-1:0] == rd_ptr_q[BUF_AW-1:0]);
    assign ceff_new   = (cut_num < total_num) ? cut_num : total_num;
    assign rd_word    = buf_mem[rd_ptr_q[BUF_AW-1:0]];

    // Control edge detectors
    always_comb begin
        start_r0_d = start_en;
        start_r1_d = start_r0_q;
        stop_r0_d  = stop_en;
        stop_r1_d  = stop_r0_q;
    end

    // Next state, write decision and buffer control
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        tot_d    = tot_q;
        ceff_d   = ceff_q;
        ovf_d    = ovf_q;
        wr_en_d  = 1'b0;
        wr_dat_d = '0;
        flush    = 1'b0;
        pop      = 1'b0;
        push_req = 1'b0;
        push_ok  = 1'b0;
`ifdef CUT_PAD_TAG_EN
        frame_seq_d = frame_seq_q;
`endif

        if (stop_edge) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
            wcnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        tot_d  = total_num;
                        ceff_d = ceff_new;
                        wcnt_d = '0;
                        ovf_d  = 1'b0;
                        flush  = 1'b1;
`ifdef CUT_PAD_TAG_EN
                        frame_seq_d = 16'd0;
`endif
                        if (total_num != '0) begin
                            state_d = (ceff_new == '0) ? ST_PAD : ST_PASS;
                        end
                    end
                end
                ST_PASS: begin
                    if (!buf_empty && space) begin
                        pop      = 1'b1;
                        wr_en_d  = 1'b1;
                        wr_dat_d = rd_word;
                        wcnt_d   = wcnt_q + 32'd1;
                        if (wcnt_q == ceff_q - 32'd1) begin
                            if (ceff_q < tot_q) begin
                                state_d = ST_PAD;
                            end else begin
                                wcnt_d = '0;
`ifdef CUT_PAD_TAG_EN
                                frame_seq_d = frame_seq_q + 16'd1;
`endif
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (space) begin
                        wr_en_d  = 1'b1;
                        wr_dat_d = fill_dat;
`ifdef CUT_PAD_TAG_EN
                        if (wcnt_q == ceff_q) begin
                            wr_dat_d = frame_seq_q;
                        end
`endif
                        wcnt_d = wcnt_q + 32'd1;
                        if (wcnt_q == tot_q - 32'd1) begin
                            wcnt_d  = '0;
                            state_d = (ceff_q == '0) ? ST_PAD : ST_PASS;
`ifdef CUT_PAD_TAG_EN
                            frame_seq_d = frame_seq_q + 16'd1;
`endif
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A pop in the same cycle frees the slot for an incoming word
            push_req = en_in && (state_q != ST_IDLE) && !flush;
            push_ok  = push_req && (!buf_full || pop);
            if (push_req && buf_full && !pop) begin
                ovf_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Buffer pointers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Buffer storage (no reset needed, guarded by pointers)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            buf_mem[wr_ptr_q[BUF_AW-1:0]] <= dat_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            start_r0_q <= 1'b0;
            start_r1_q <= 1'b0;
            stop_r0_q  <= 1'b0;
            stop_r1_q  <= 1'b0;
            wcnt_q     <= '0;
            tot_q      <= '0;
            ceff_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_dat_q   <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef CUT_PAD_TAG_EN
            frame_seq_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            start_r0_q <= start_r0_d;
            start_r1_q <= start_r1_d;
            stop_r0_q  <= stop_r0_d;
            stop_r1_q  <= stop_r1_d;
            wcnt_q     <= wcnt_d;
            tot_q      <= tot_d;
            ceff_q     <= ceff_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_dat_q   <= wr_dat_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
`ifdef CUT_PAD_TAG_EN
            frame_seq_q <= frame_seq_d;
`endif
        end
    end

    assign wr_en  = wr_en_q;
    assign wr_dat = wr_dat_q;
    assign busy   = busy_q;
    assign ovf    = ovf_q;

endmodule
